// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the E stage.
// The result is computed combinationally when a command is accepted and held
// in pending registers. busy then counts out the operation's latency, and the
// pending values are copied into HI/LO on the final edge. HI/LO are plain
// register outputs. A consumer must stall on busy.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  op,
   input  logic        start,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [4:0] MULT_LAST = 5'(MULT_CYCLES - 1);
   localparam logic [4:0] DIV_LAST  = 5'(DIV_CYCLES - 1);

   // Signed divide on magnitudes. The quotient truncates toward zero and the
   // remainder takes the dividend's sign. The case 0x80000000 / -1 falls out
   // naturally as quotient 0x80000000, remainder 0. Returns {rem, quo}.
   function automatic logic [63:0] f_div_s(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] mag_a;
      logic [31:0] mag_b;
      logic [31:0] q;
      logic [31:0] r;
      mag_a = a[31] ? (~a + 32'd1) : a;
      mag_b = b[31] ? (~b + 32'd1) : b;
      if (mag_b == 32'd0) begin
         q = 32'd0;
         r = 32'd0;
      end else begin
         q = mag_a / mag_b;
         r = mag_a % mag_b;
      end
      if (a[31] ^ b[31]) q = ~q + 32'd1;
      if (a[31])         r = ~r + 32'd1;
      return {r, q};
   endfunction

   // Unsigned divide. A zero divisor yields 0; the caller suppresses the commit.
   function automatic logic [63:0] f_div_u(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) begin
         q = 32'd0;
         r = 32'd0;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   logic signed [63:0] w_a_sx;
   logic signed [63:0] w_b_sx;
   logic signed [63:0] w_prod_s;
   logic        [63:0] w_prod_u;
   logic        [63:0] w_div_s;
   logic        [63:0] w_div_u;
   logic        [31:0] w_res_hi;
   logic        [31:0] w_res_lo;
   logic               w_res_wr;
   logic               w_valid_op;
   logic               w_accept;
   logic        [4:0]  w_cnt_init;

   logic               r_busy;
   logic        [4:0]  r_cnt;
   logic        [31:0] r_hi;
   logic        [31:0] r_lo;
   logic        [31:0] r_pend_hi;
   logic        [31:0] r_pend_lo;
   logic               r_pend_wr;

   assign w_a_sx   = {{32{A[31]}}, A};
   assign w_b_sx   = {{32{B[31]}}, B};
   assign w_prod_s = w_a_sx * w_b_sx;
   assign w_prod_u = {32'd0, A} * {32'd0, B};
   assign w_div_s  = f_div_s(A, B);
   assign w_div_u  = f_div_u(A, B);

   assign w_valid_op = (op >= OP_MULT) && (op <= OP_MTLO);
   assign w_accept   = start && !flush && !r_busy && w_valid_op;
   assign w_cnt_init = ((op == OP_MULT) || (op == OP_MULTU)) ? MULT_LAST : DIV_LAST;

   // Select the result for a long operation. A zero divisor marks it as no-write.
   always_comb begin
      w_res_hi = 32'd0;
      w_res_lo = 32'd0;
      w_res_wr = 1'b0;
      case (op)
         OP_MULT: begin
            {w_res_hi, w_res_lo} = w_prod_s;
            w_res_wr = 1'b1;
         end
         OP_MULTU: begin
            {w_res_hi, w_res_lo} = w_prod_u;
            w_res_wr = 1'b1;
         end
         OP_DIV: begin
            {w_res_hi, w_res_lo} = w_div_s;
            w_res_wr = (B != 32'd0);
         end
         OP_DIVU: begin
            {w_res_hi, w_res_lo} = w_div_u;
            w_res_wr = (B != 32'd0);
         end
         default: begin
            w_res_wr = 1'b0;
         end
      endcase
   end

   // Accept commands, count the busy window, and commit pending results to HI/LO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy    <= 1'b0;
         r_cnt     <= 5'd0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_pend_wr <= 1'b0;
      end else if (r_busy) begin
         if (r_cnt == 5'd0) begin
            r_busy <= 1'b0;
            if (r_pend_wr) begin
               r_hi <= r_pend_hi;
               r_lo <= r_pend_lo;
            end
         end else begin
            r_cnt <= r_cnt - 5'd1;
         end
      end else if (w_accept) begin
         case (op)
            OP_MTHI: r_hi <= A;
            OP_MTLO: r_lo <= A;
            default: begin
               r_pend_hi <= w_res_hi;
               r_pend_lo <= w_res_lo;
               r_pend_wr <= w_res_wr;
               r_busy    <= 1'b1;
               r_cnt     <= w_cnt_init;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit.
// The stimulus side runs a cycle-level reference model (architectural HI/LO
// and remaining busy cycles). For each long operation it queues the expected
// commit. A monitor watches busy. On every busy cycle it checks that HI/LO
// still hold the old values. When busy falls, it pops the queue and checks the
// committed values and the busy length.
module tb_mult_div_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset_n;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic [2:0]  op_i;
   logic        start_i;
   logic        flush_i;
   logic        busy_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset_n),
      .A     (a_i),
      .B     (b_i),
      .op    (op_i),
      .start (start_i),
      .flush (flush_i),
      .busy  (busy_o),
      .HI    (hi_o),
      .LO    (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } sb_t;

   sb_t         sbq[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   int          busy_left = 0;
   bit          mon_prev = 1'b0;
   int          mon_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour from the architectural rules.
   function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] oh, input logic [31:0] ol,
                                  output logic [31:0] nh, output logic [31:0] nl);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub, uq, ur;
      nh = oh;
      nl = ol;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         3'd1: begin q = sa * sb; nh = q[63:32]; nl = q[31:0]; end
         3'd2: begin uq = ua * ub; nh = uq[63:32]; nl = uq[31:0]; end
         3'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
         3'd4: if (b != 32'd0) begin uq = ua / ub; ur = ua % ub; nl = uq[31:0]; nh = ur[31:0]; end
         default: ;
      endcase
   endfunction

   // One clock of stimulus. The model is advanced at the edge and the
   // architectural state is checked just after it.
   task automatic do_cycle(input logic [2:0] o, input logic s, input logic f,
                           input logic [31:0] a, input logic [31:0] b, input bit nowait = 1'b0);
      bit          acc;
      logic [31:0] nh, nl;
      sb_t         it;
      if (!nowait) begin
         @(negedge clk);
         #1;
      end
      op_i = o; start_i = s; flush_i = f; a_i = a; b_i = b;
      @(posedge clk);
      acc = s && !f && (busy_left == 0) && (o >= 3'd1) && (o <= 3'd6);
      if (acc) begin
         if (o == 3'd5)      m_hi = a;
         else if (o == 3'd6) m_lo = a;
         else begin
            ref_op(o, a, b, m_hi, m_lo, nh, nl);
            it.old_hi = m_hi; it.old_lo = m_lo; it.hi = nh; it.lo = nl;
            it.cyc = (o <= 3'd2) ? MC : DC;
            sbq.push_back(it);
            m_hi = nh; m_lo = nl;
            busy_left = it.cyc;
         end
      end else if (busy_left > 0) begin
         busy_left--;
      end
      #1;
      if (busy_left == 0) begin
         chk("busy_idle", 32'(busy_o), 32'd0);
         chk("hi_state", hi_o, m_hi);
         chk("lo_state", lo_o, m_lo);
      end else begin
         chk("busy_run", 32'(busy_o), 32'd1);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cycle(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic drain();
      while (busy_left > 0) do_cycle(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   // Pulse reset mid-cycle. HI/LO/busy must clear at once, independent of clk.
   // The function release lines up with the next command, which is issued nowait.
   task automatic pulse_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      start_i = 1'b0;
      #1;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_hi", hi_o, 32'd0);
      chk("rst_lo", lo_o, 32'd0);
      sbq.delete();
      m_hi = 32'd0; m_lo = 32'd0; busy_left = 0;
      @(negedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // Monitor: compare against the scoreboard whenever the DUT is busy or finishes.
   always @(negedge clk) begin
      if (!reset_n) begin
         mon_prev = 1'b0;
         mon_cnt  = 0;
      end else begin
         if (busy_o) begin
            mon_cnt++;
            if (sbq.size() > 0) begin
               chk("hold_hi", hi_o, sbq[0].old_hi);
               chk("hold_lo", lo_o, sbq[0].old_lo);
            end
         end else if (mon_prev) begin
            if (sbq.size() == 0) begin
               chk("unexpected_commit", 32'd1, 32'd0);
            end else begin
               chk("commit_hi", hi_o, sbq[0].hi);
               chk("commit_lo", lo_o, sbq[0].lo);
               chk("busy_len", 32'(mon_cnt), 32'(sbq[0].cyc));
               void'(sbq.pop_front());
            end
         end
         if (!busy_o) mon_cnt = 0;
         mon_prev = busy_o;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      reset_n = 1'b0;
      a_i = 32'd0; b_i = 32'd0; op_i = 3'd0; start_i = 1'b0; flush_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy_o), 32'd0);
      chk("reset_hi", hi_o, 32'd0);
      chk("reset_lo", lo_o, 32'd0);
      #1;
      reset_n = 1'b1;

      // Signed multiply of -2 by 3.
      do_cycle(3'd1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3);
      drain();
      chk("mult_hi", hi_o, 32'hFFFF_FFFF);
      chk("mult_lo", lo_o, 32'hFFFF_FFFA);

      // Unsigned multiply of all-ones operands.
      do_cycle(3'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drain();
      chk("multu_hi", hi_o, 32'hFFFF_FFFE);
      chk("multu_lo", lo_o, 32'h0000_0001);

      // Signed divide of -7 by 2, then unsigned divide by zero.
      do_cycle(3'd3, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
      drain();
      chk("div_lo", lo_o, 32'hFFFF_FFFD);
      chk("div_hi", hi_o, 32'hFFFF_FFFF);
      do_cycle(3'd4, 1'b1, 1'b0, 32'd1234, 32'd0);
      drain();
      chk("divu0_hi", hi_o, 32'hFFFF_FFFF);
      chk("divu0_lo", lo_o, 32'hFFFF_FFFD);

      // Divide overflow case: 0x80000000 / -1.
      do_cycle(3'd3, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      drain();
      chk("divovf_lo", lo_o, 32'h8000_0000);
      chk("divovf_hi", hi_o, 32'h0000_0000);

      // MTLO during busy is ignored; MTLO after busy clears takes effect.
      do_cycle(3'd1, 1'b1, 1'b0, 32'd3, 32'd5);
      do_cycle(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      do_cycle(3'd6, 1'b1, 1'b0, 32'h1234, 32'd0);
      drain();
      chk("mult_during_lo", lo_o, 32'd15);
      do_cycle(3'd6, 1'b1, 1'b0, 32'h1234, 32'd0);
      chk("mtlo_lo", lo_o, 32'h0000_1234);
      do_cycle(3'd5, 1'b1, 1'b0, 32'hCAFE_F00D, 32'd0);
      chk("mthi_hi", hi_o, 32'hCAFE_F00D);

      // A flushed start is not accepted.
      do_cycle(3'd3, 1'b1, 1'b1, 32'd100, 32'd7);
      chk("flush_busy", 32'(busy_o), 32'd0);
      chk("flush_lo", lo_o, 32'h0000_1234);

      // Reset during DIVU abandons it; a start right after reset release is taken.
      do_cycle(3'd4, 1'b1, 1'b0, 32'd100, 32'd7);
      idle(2);
      pulse_reset();
      do_cycle(3'd5, 1'b1, 1'b0, 32'h0000_ABCD, 32'd0, 1'b1);
      chk("post_rst_hi", hi_o, 32'h0000_ABCD);
      idle(DC + 2);
      chk("no_commit_lo", lo_o, 32'd0);

      // Randomized traffic, including starts while busy and flushes.
      for (int i = 0; i < 300; i++) begin
         ro = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0:       ra = 32'h8000_0000;
            1:       ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 9));
            default: rb = $urandom;
         endcase
         do_cycle(ro, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), ra, rb);
      end
      drain();
      idle(3);
      chk("sb_drain", 32'(sbq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU (legal range 1-31).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU (legal range 1-31).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port A  input  32  operand rs, E-stage forwarded GRF read data.
REQ-006 SHALL have port B  input  32  operand rt, E-stage forwarded GRF read data.
REQ-007 SHALL have port op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 behaves as NOP.
REQ-008 SHALL have port start  input  1  op valid this cycle.
REQ-009 SHALL have port flush  input  1  exception/interrupt in E stage; start suppressed.
REQ-010 SHALL have port busy  output  1  operation in progress; stall source for D stage.
REQ-011 SHALL have port HI  output  32  architectural HI register.
REQ-012 SHALL have port LO  output  32  architectural LO register.

Function
REQ-013 SHALL accept a command at a rising edge only if start=1, flush=0, busy=0 and op is 1-6; otherwise the edge changes no state.
REQ-014 SHALL write MTHI: HI<=A, and MTLO: LO<=A, at the accepting edge; busy stays 0.
REQ-015 SHALL, for MULT/MULTU/DIV/DIVU, capture the result into internal pending registers at the accepting edge and set busy=1 plus the counter to N-1 (N = MULT_CYCLES or DIV_CYCLES).
REQ-016 SHALL decrement the counter at each edge while busy=1; at the edge where the counter is 0, it SHALL copy the pending values to HI/LO and clear busy, all in that one edge.
REQ-017 SHALL hold busy high for exactly N cycles after the accepting edge; HI/LO SHALL keep their old values until the commit edge.
REQ-018 SHALL form MULT results as the 64-bit signed product, with HI = bits 63:32 and LO = bits 31:0; MULTU SHALL form the unsigned product in the same layout.
REQ-019 SHALL form DIV results as LO = quotient truncated toward zero and HI = remainder with the sign of the dividend; DIVU SHALL be unsigned.
REQ-020 SHALL handle B=0 on DIV/DIVU as follows: busy runs the full DIV_CYCLES, and HI/LO are left unchanged at commit.
REQ-021 SHALL produce LO=0x80000000, HI=0 for DIV of A=0x80000000 by B=0xFFFFFFFF, with no trap.
REQ-022 SHALL ignore start while busy=1 (no queueing); the in-flight operation SHALL be unaffected.
REQ-023 SHALL leave an in-flight operation unaffected when flush=1 during busy; flush only blocks acceptance.
REQ-024 SHALL give busy a combinational dependence on no input; busy SHALL be a register output.
REQ-025 SHALL drive HI/LO directly from registers, with no write-through bypass; the consumer stalls on busy.

Reset
REQ-026 SHALL, while reset=0, immediately force HI=0, LO=0, busy=0, counter=0 and pending registers=0, independent of clk.
REQ-027 SHALL abandon any in-flight operation when reset is asserted mid-operation; that operation SHALL never commit.
REQ-028 SHALL accept a start at the first rising edge after reset rises.

Verification
REQ-029 SHALL be verified with: MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 SHALL be verified with: MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001; HI/LO unchanged during cycles 1-4.
REQ-031 SHALL be verified with: DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIVU with B=0 -> busy 10 cycles, HI/LO unchanged.
REQ-032 SHALL be verified with: MULT started, then MTLO A=0x1234 during busy cycle 2 -> MTLO ignored, product committed; a following MTLO with busy=0 -> LO=0x1234 next edge.
REQ-033 SHALL be verified with: start=1, op=DIV, flush=1 -> busy stays 0 and HI/LO unchanged.
REQ-034 SHALL be verified with: DIVU started, reset pulsed low in cycle 4 -> HI=LO=0 and busy=0 immediately, with no later commit.
